// File: rtl/wb_copy_master.sv
// Wishbone B.4 pipelined master: copies LEN words from SRC+n to DST+n,
// one read then one write per word, never more than one strobe outstanding.
module wb_copy_master #(
   parameter int unsigned ADDR_WIDTH  = 16,
   parameter int unsigned DATA_WIDTH  = 16,
   parameter int unsigned COUNT_WIDTH = 8
) (
   input  logic                   clk_i,
   input  logic                   reset_i,
   input  logic                   start_i,
   input  logic [ADDR_WIDTH-1:0]  src_i,
   input  logic [ADDR_WIDTH-1:0]  dst_i,
   input  logic [COUNT_WIDTH-1:0] len_i,
   output logic                   busy_o,
   output logic                   done_o,
   output logic                   err_o,
   output logic [ADDR_WIDTH-1:0]  adr_o,
   output logic [DATA_WIDTH-1:0]  dat_o,
   output logic                   cyc_o,
   output logic                   stb_o,
   output logic                   we_o,
   input  logic [DATA_WIDTH-1:0]  dat_i,
   input  logic                   ack_i,
   input  logic                   stall_i,
   input  logic                   err_i
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RD_REQ  = 3'd1,
      RD_WAIT = 3'd2,
      WR_REQ  = 3'd3,
      WR_WAIT = 3'd4,
      FIN     = 3'd5
   } state_t;

   state_t                 state_q, state_d;
   logic [ADDR_WIDTH-1:0]  src_q, src_d;
   logic [ADDR_WIDTH-1:0]  dst_q, dst_d;
   logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0]  data_q, data_d;

   logic                   busy_q, busy_d;
   logic                   done_q, done_d;
   logic                   err_q, err_d;
   logic [ADDR_WIDTH-1:0]  adr_q, adr_d;
   logic [DATA_WIDTH-1:0]  dat_q, dat_d;
   logic                   cyc_q, cyc_d;
   logic                   stb_q, stb_d;
   logic                   we_q, we_d;

   logic                   abort_c;
   logic                   wr_done_c;

   // State register, working registers and registered bus outputs
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q <= IDLE;
         src_q   <= '0;
         dst_q   <= '0;
         cnt_q   <= '0;
         data_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         adr_q   <= '0;
         dat_q   <= '0;
         cyc_q   <= 1'b0;
         stb_q   <= 1'b0;
         we_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         src_q   <= src_d;
         dst_q   <= dst_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         err_q   <= err_d;
         adr_q   <= adr_d;
         dat_q   <= dat_d;
         cyc_q   <= cyc_d;
         stb_q   <= stb_d;
         we_q    <= we_d;
      end
   end

   // Next-state logic; outputs are decoded from the next state so they register cleanly
   always_comb begin
      state_d   = state_q;
      src_d     = src_q;
      dst_d     = dst_q;
      cnt_d     = cnt_q;
      data_d    = data_q;
      abort_c   = 1'b0;
      wr_done_c = 1'b0;

      case (state_q)
         IDLE: begin
            if (start_i) begin
               if (len_i != '0) begin
                  src_d   = src_i;
                  dst_d   = dst_i;
                  cnt_d   = len_i;
                  state_d = RD_REQ;
               end else begin
                  state_d = FIN;
               end
            end
         end
         RD_REQ: begin
            if (err_i) begin
               abort_c = 1'b1;
            end else if (!stall_i) begin
               if (ack_i) begin
                  data_d  = dat_i;
                  state_d = WR_REQ;
               end else begin
                  state_d = RD_WAIT;
               end
            end
         end
         RD_WAIT: begin
            if (err_i) begin
               abort_c = 1'b1;
            end else if (ack_i) begin
               data_d  = dat_i;
               state_d = WR_REQ;
            end
         end
         WR_REQ: begin
            if (err_i) begin
               abort_c = 1'b1;
            end else if (!stall_i) begin
               if (ack_i) begin
                  wr_done_c = 1'b1;
               end else begin
                  state_d = WR_WAIT;
               end
            end
         end
         WR_WAIT: begin
            if (err_i) begin
               abort_c = 1'b1;
            end else if (ack_i) begin
               wr_done_c = 1'b1;
            end
         end
         FIN: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Word finished: advance both pointers (wrapping) and count down
      if (wr_done_c) begin
         src_d   = src_q + ADDR_WIDTH'(1);
         dst_d   = dst_q + ADDR_WIDTH'(1);
         cnt_d   = cnt_q - COUNT_WIDTH'(1);
         state_d = (cnt_q == COUNT_WIDTH'(1)) ? FIN : RD_REQ;
      end

      if (abort_c) begin
         state_d = FIN;
      end

      busy_d = (state_d != IDLE);
      done_d = (state_d == FIN);
      err_d  = abort_c;
      cyc_d  = (state_d == RD_REQ) || (state_d == RD_WAIT) ||
               (state_d == WR_REQ) || (state_d == WR_WAIT);
      stb_d  = (state_d == RD_REQ) || (state_d == WR_REQ);
      we_d   = (state_d == WR_REQ);
      adr_d  = (state_d == RD_REQ) ? src_d :
               (state_d == WR_REQ) ? dst_d : '0;
      dat_d  = (state_d == WR_REQ) ? data_d : '0;
   end

   assign busy_o = busy_q;
   assign done_o = done_q;
   assign err_o  = err_q;
   assign adr_o  = adr_q;
   assign dat_o  = dat_q;
   assign cyc_o  = cyc_q;
   assign stb_o  = stb_q;
   assign we_o   = we_q;

endmodule

// File: tb/tb_wb_copy_master.sv
// Directed bench for wb_copy_master: cycle-by-cycle checks of the bus outputs.
module tb_wb_copy_master;

   logic        clk_i = 1'b0;
   logic        reset_i;
   logic        start_i;
   logic [15:0] src_i;
   logic [15:0] dst_i;
   logic [7:0]  len_i;
   logic        busy_o;
   logic        done_o;
   logic        err_o;
   logic [15:0] adr_o;
   logic [15:0] dat_o;
   logic        cyc_o;
   logic        stb_o;
   logic        we_o;
   logic [15:0] dat_i;
   logic        ack_i;
   logic        stall_i;
   logic        err_i;

   int total = 0;
   int bad   = 0;

   wb_copy_master #(
      .ADDR_WIDTH (16),
      .DATA_WIDTH (16),
      .COUNT_WIDTH(8)
   ) dut (
      .clk_i  (clk_i),
      .reset_i(reset_i),
      .start_i(start_i),
      .src_i  (src_i),
      .dst_i  (dst_i),
      .len_i  (len_i),
      .busy_o (busy_o),
      .done_o (done_o),
      .err_o  (err_o),
      .adr_o  (adr_o),
      .dat_o  (dat_o),
      .cyc_o  (cyc_o),
      .stb_o  (stb_o),
      .we_o   (we_o),
      .dat_i  (dat_i),
      .ack_i  (ack_i),
      .stall_i(stall_i),
      .err_i  (err_i)
   );

   always #5 clk_i = ~clk_i;

   // Observed outputs packed as {cyc, stb, we, adr, dat, busy, done, err}
   logic [37:0] obs;
   assign obs = {cyc_o, stb_o, we_o, adr_o, dat_o, busy_o, done_o, err_o};

   // Expected-vector builder in the same packing as obs
   function automatic logic [37:0] ev(input logic cyc, input logic stb, input logic we,
                                      input logic [15:0] adr, input logic [15:0] dat,
                                      input logic busy, input logic done, input logic err);
      return {cyc, stb, we, adr, dat, busy, done, err};
   endfunction

   localparam logic [37:0] IDLE_V = 38'h0;

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic test_reset();
      logic [37:0] e;
      reset_i = 1'b1; start_i = 1'b0; src_i = '0; dst_i = '0; len_i = '0;
      dat_i = '0; ack_i = 1'b0; stall_i = 1'b0; err_i = 1'b0;
      step();
      step();
      reset_i = 1'b0;
      e = IDLE_V;
      step();
      total++;
      if (obs !== e) begin bad++; $display("FAIL reset_idle0 got=%h exp=%h", obs, e); end
      step();
      total++;
      if (obs !== e) begin bad++; $display("FAIL reset_idle1 got=%h exp=%h", obs, e); end
   endtask

   task automatic test_basic();
      logic [37:0] e;
      src_i = 16'h0100; dst_i = 16'h2000; len_i = 8'd2;
      ack_i = 1'b1; stall_i = 1'b0; dat_i = 16'h1111; start_i = 1'b1;
      step();
      start_i = 1'b0;
      e = ev(1, 1, 0, 16'h0100, 16'h0000, 1, 0, 0);
      total++;
      if (obs !== e) begin bad++; $display("FAIL basic_rd0 got=%h exp=%h", obs, e); end
      step();
      e = ev(1, 1, 1, 16'h2000, 16'h1111, 1, 0, 0);
      total++;
      if (obs !== e) begin bad++; $display("FAIL basic_wr0 got=%h exp=%h", obs, e); end
      dat_i = 16'h2222;
      start_i = 1'b1;  // must be ignored while busy
      step();
      e = ev(1, 1, 0, 16'h0101, 16'h0000, 1, 0, 0);
      total++;
      if (obs !== e) begin bad++; $display("FAIL basic_rd1 got=%h exp=%h", obs, e); end
      step();
      start_i = 1'b0;
      e = ev(1, 1, 1, 16'h2001, 16'h2222, 1, 0, 0);
      total++;
      if (obs !== e) begin bad++; $display("FAIL basic_wr1 got=%h exp=%h", obs, e); end
      step();
      e = ev(0, 0, 0, 16'h0000, 16'h0000, 1, 1, 0);
      total++;
      if (obs !== e) begin bad++; $display("FAIL basic_fin got=%h exp=%h", obs, e); end
      ack_i = 1'b0;
      step();
      e = IDLE_V;
      total++;
      if (obs !== e) begin bad++; $display("FAIL basic_idle got=%h exp=%h", obs, e); end
   endtask

   task automatic test_stall();
      logic [37:0] e;
      src_i = 16'h0300; dst_i = 16'h0400; len_i = 8'd1;
      ack_i = 1'b0; stall_i = 1'b1; dat_i = 16'h0000; start_i = 1'b1;
      step();
      start_i = 1'b0;
      e = ev(1, 1, 0, 16'h0300, 16'h0000, 1, 0, 0);
      total++;
      if (obs !== e) begin bad++; $display("FAIL stall_rd got=%h exp=%h", obs, e); end
      step();
      total++;
      if (obs !== e) begin bad++; $display("FAIL stall_hold0 got=%h exp=%h", obs, e); end
      step();
      total++;
      if (obs !== e) begin bad++; $display("FAIL stall_hold1 got=%h exp=%h", obs, e); end
      stall_i = 1'b0;
      step();
      e = ev(1, 0, 0, 16'h0000, 16'h0000, 1, 0, 0);
      total++;
      if (obs !== e) begin bad++; $display("FAIL stall_rdwait got=%h exp=%h", obs, e); end
      ack_i = 1'b1; dat_i = 16'hBEEF;
      step();
      dat_i = 16'h0000;
      e = ev(1, 1, 1, 16'h0400, 16'hBEEF, 1, 0, 0);
      total++;
      if (obs !== e) begin bad++; $display("FAIL stall_wr got=%h exp=%h", obs, e); end
      step();
      e = ev(0, 0, 0, 16'h0000, 16'h0000, 1, 1, 0);
      total++;
      if (obs !== e) begin bad++; $display("FAIL stall_fin got=%h exp=%h", obs, e); end
      ack_i = 1'b0;
      step();
   endtask

   task automatic test_wrap();
      logic [37:0] e;
      src_i = 16'hFFFF; dst_i = 16'hFFFF; len_i = 8'd2;
      ack_i = 1'b1; stall_i = 1'b0; dat_i = 16'h0A0A; start_i = 1'b1;
      step();
      start_i = 1'b0;
      e = ev(1, 1, 0, 16'hFFFF, 16'h0000, 1, 0, 0);
      total++;
      if (obs !== e) begin bad++; $display("FAIL wrap_rd0 got=%h exp=%h", obs, e); end
      step();
      e = ev(1, 1, 1, 16'hFFFF, 16'h0A0A, 1, 0, 0);
      total++;
      if (obs !== e) begin bad++; $display("FAIL wrap_wr0 got=%h exp=%h", obs, e); end
      dat_i = 16'h0B0B;
      step();
      e = ev(1, 1, 0, 16'h0000, 16'h0000, 1, 0, 0);
      total++;
      if (obs !== e) begin bad++; $display("FAIL wrap_rd1 got=%h exp=%h", obs, e); end
      step();
      e = ev(1, 1, 1, 16'h0000, 16'h0B0B, 1, 0, 0);
      total++;
      if (obs !== e) begin bad++; $display("FAIL wrap_wr1 got=%h exp=%h", obs, e); end
      step();
      e = ev(0, 0, 0, 16'h0000, 16'h0000, 1, 1, 0);
      total++;
      if (obs !== e) begin bad++; $display("FAIL wrap_fin got=%h exp=%h", obs, e); end
      ack_i = 1'b0;
      step();
   endtask

   task automatic test_err();
      logic [37:0] e;
      src_i = 16'h0500; dst_i = 16'h0600; len_i = 8'd3;
      ack_i = 1'b1; stall_i = 1'b0; dat_i = 16'h5555; start_i = 1'b1;
      step();
      start_i = 1'b0;
      step();
      e = ev(1, 1, 1, 16'h0600, 16'h5555, 1, 0, 0);
      total++;
      if (obs !== e) begin bad++; $display("FAIL err_wr got=%h exp=%h", obs, e); end
      ack_i = 1'b0;
      step();
      e = ev(1, 0, 0, 16'h0000, 16'h0000, 1, 0, 0);
      total++;
      if (obs !== e) begin bad++; $display("FAIL err_wrwait got=%h exp=%h", obs, e); end
      err_i = 1'b1; ack_i = 1'b1;  // abort must win over a coincident ack
      step();
      err_i = 1'b0; ack_i = 1'b0;
      e = ev(0, 0, 0, 16'h0000, 16'h0000, 1, 1, 1);
      total++;
      if (obs !== e) begin bad++; $display("FAIL err_fin got=%h exp=%h", obs, e); end
      step();
      e = IDLE_V;
      total++;
      if (obs !== e) begin bad++; $display("FAIL err_idle0 got=%h exp=%h", obs, e); end
      step();
      total++;
      if (obs !== e) begin bad++; $display("FAIL err_idle1 got=%h exp=%h", obs, e); end
      src_i = 16'h0700; dst_i = 16'h0800; len_i = 8'd1;
      ack_i = 1'b1; dat_i = 16'h7777; start_i = 1'b1;
      step();
      start_i = 1'b0;
      e = ev(1, 1, 0, 16'h0700, 16'h0000, 1, 0, 0);
      total++;
      if (obs !== e) begin bad++; $display("FAIL err_restart_rd got=%h exp=%h", obs, e); end
      step();
      e = ev(1, 1, 1, 16'h0800, 16'h7777, 1, 0, 0);
      total++;
      if (obs !== e) begin bad++; $display("FAIL err_restart_wr got=%h exp=%h", obs, e); end
      step();
      e = ev(0, 0, 0, 16'h0000, 16'h0000, 1, 1, 0);
      total++;
      if (obs !== e) begin bad++; $display("FAIL err_restart_fin got=%h exp=%h", obs, e); end
      ack_i = 1'b0;
      step();
   endtask

   task automatic test_len0_and_reset();
      logic [37:0] e;
      src_i = 16'h0900; dst_i = 16'h0A00; len_i = 8'd0;
      ack_i = 1'b0; stall_i = 1'b0; start_i = 1'b1;
      step();
      start_i = 1'b0;
      e = ev(0, 0, 0, 16'h0000, 16'h0000, 1, 1, 0);
      total++;
      if (obs !== e) begin bad++; $display("FAIL len0_fin got=%h exp=%h", obs, e); end
      step();
      e = IDLE_V;
      total++;
      if (obs !== e) begin bad++; $display("FAIL len0_idle got=%h exp=%h", obs, e); end

      src_i = 16'h0800; dst_i = 16'h0C00; len_i = 8'd2; start_i = 1'b1;
      step();
      start_i = 1'b0;
      step();
      e = ev(1, 0, 0, 16'h0000, 16'h0000, 1, 0, 0);
      total++;
      if (obs !== e) begin bad++; $display("FAIL rst_rdwait got=%h exp=%h", obs, e); end
      reset_i = 1'b1;
      step();
      reset_i = 1'b0;
      e = IDLE_V;
      total++;
      if (obs !== e) begin bad++; $display("FAIL rst_mid got=%h exp=%h", obs, e); end
      ack_i = 1'b1;  // a late ack must not revive the abandoned transfer
      step();
      total++;
      if (obs !== e) begin bad++; $display("FAIL rst_after0 got=%h exp=%h", obs, e); end
      ack_i = 1'b0;
      step();
      total++;
      if (obs !== e) begin bad++; $display("FAIL rst_after1 got=%h exp=%h", obs, e); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_stall();
      test_wrap();
      test_err();
      test_len0_and_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/wb_copy_master.md
Name: wb_copy_master

Overview:
Parametrised Wishbone B.4 pipelined bus master that copies a block of LEN words from a source address range to a destination address range. Each word is a read from SRC+n, with the data latched, followed by a write to DST+n. At most one outstanding strobe is permitted: one strobe, one ack, in that order. The block sits behind a trigger from the boot/IPL sequencer, or any client needing a memory-to-memory move, and adds STALL_I, ERR_I, a data path and burst length handling.

Parameters:
ADDR_WIDTH, 16, width of adr_o, src_i and dst_i (word addresses).
DATA_WIDTH, 16, width of dat_i and dat_o.
COUNT_WIDTH, 8, width of len_i; maximum burst is 2^COUNT_WIDTH-1 words.

Ports:
clk_i  in  1  system clock; all logic on the rising edge.
reset_i  in  1  synchronous, active-high reset.
start_i  in  1  request a copy; sampled only in IDLE.
src_i  in  ADDR_WIDTH  first source address; latched on an accepted start.
dst_i  in  ADDR_WIDTH  first destination address; latched on an accepted start.
len_i  in  COUNT_WIDTH  number of words; latched on an accepted start.
busy_o  out  1  high from the cycle after an accepted start until done_o.
done_o  out  1  one-cycle pulse when the copy ends (normally or aborted).
err_o  out  1  one-cycle pulse, coincident with done_o, when aborted by err_i.
adr_o  out  ADDR_WIDTH  bus address; 0 whenever stb_o=0.
dat_o  out  DATA_WIDTH  write data; 0 unless a write strobe is presented.
cyc_o  out  1  bus cycle.
stb_o  out  1  strobe.
we_o  out  1  write enable; 1 only while a write strobe is presented.
dat_i  in  DATA_WIDTH  read data, valid with ack_i.
ack_i  in  1  slave acknowledge.
stall_i  in  1  slave cannot accept the strobe this cycle.
err_i  in  1  slave error termination.

Behaviour:
- Reset (synchronous, active-high): the state goes to IDLE. All outputs are 0 the cycle after the reset edge. This includes an in-progress transfer, which is abandoned with no done_o.
- States: IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, FIN.
- Registered outputs per state:
  - cyc_o=1 in RD_REQ, RD_WAIT, WR_REQ and WR_WAIT.
  - stb_o=1 only in RD_REQ and WR_REQ.
  - we_o=1 only in WR_REQ.
  - adr_o=src in RD_REQ and dst in WR_REQ; 0 otherwise.
  - dat_o=latched word in WR_REQ; 0 otherwise.
- IDLE:
  - start_i=1 with len_i≠0: latch src, dst and len, then go to RD_REQ. cyc_o and stb_o assert the next cycle, with adr_o=src_i.
  - start_i=1 with len_i=0: go to FIN; no bus activity occurs.
- REQ states (RD_REQ, WR_REQ):
  - stall_i=1: hold the state and all outputs unchanged.
  - stall_i=0: the strobe is accepted. If ack_i=1 in the same cycle, the step completes immediately; otherwise go to the matching WAIT state, where stb_o=0 and adr_o=0.
- WAIT states: hold until ack_i=1. stall_i is ignored here.
- Read completion (ack_i in RD_REQ-accepted or RD_WAIT): capture dat_i, then go to WR_REQ.
- Write completion (ack_i in WR_REQ-accepted or WR_WAIT):
  - Decrement the remaining count and increment src and dst by 1, modulo 2^ADDR_WIDTH (wrap-around; no fault).
  - Remaining count ≠ 0: go to RD_REQ with cyc_o held high, so no idle cycle occurs between words.
  - Remaining count = 0: go to FIN.
- Throughput: with ack_i pegged high and stall_i low, each word costs exactly 2 cycles (read strobe, then write strobe).
- FIN: done_o=1 and busy_o=1 for one cycle with cyc_o=0, then go to IDLE. start_i is ignored in FIN.
- err_i=1 in any non-IDLE bus state (RD_REQ, RD_WAIT, WR_REQ, WR_WAIT):
  - The abort takes priority over ack_i.
  - Go to FIN with err_o=1 during FIN.
  - cyc_o drops the next cycle; remaining words are not transferred.
- start_i while busy is ignored, with no queuing.
- ack_i, err_i and dat_i are ignored in IDLE and FIN.

Test Plan:
1. Reset, then idle 2 cycles -> every output is 0 in both cycles.
2. start_i=1, src=0x0100, dst=0x2000, len=2, ack_i pegged 1, stall_i=0 -> per cycle:
   - cycle 1: rd 0x0100, we_o=0
   - cycle 2: wr 0x2000, dat_o = dat_i from cycle 1
   - cycle 3: rd 0x0101
   - cycle 4: wr 0x2001
   - cycle 5: cyc_o=0, done_o=1, err_o=0
3. len=1 with stall_i=1 for 2 cycles on the read strobe, then ack 1 cycle after acceptance -> strobe and adr_o=src held through the stall; stb_o=0 and adr_o=0 during RD_WAIT; dat_i=0xBEEF latched and presented on dat_o with we_o=1; done_o after the write ack.
4. src=0xFFFF, dst=0xFFFF, len=2, ack pegged -> second read and write use address 0x0000.
5. err_i=1 during the first WR_WAIT of len=3 -> cyc_o=0 the next cycle with done_o=1 and err_o=1; no further strobes; start_i is accepted again afterwards.
6. len=0 start -> no cyc_o, done_o pulses 1 cycle later. Separately, reset_i=1 in RD_WAIT -> all outputs 0 the next cycle, no done_o.
